ahbl_arbiter: RTL
=================

Name: ahbl_arbiter

Overview:
N:1 AHB-lite arbiter that sits directly upstream of the 1:N address splitter. It merges several true masters, such as the core's I-side and D-side ports and a debug master, onto one master port that feeds the splitter's slave port. Arbitration is fixed priority. A master that loses arbitration has its address phase captured in a per-port buffer and is stalled until that transfer has been replayed and has completed.

Parameters:
N_PORTS, 2, number of upstream masters; port 0 has the highest priority.
W_ADDR, 32, address width.
W_DATA, 32, data width.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
src_hready  input  N_PORTS  per-master HREADY; at top level each is tied to its own src_hready_resp bit.
src_hready_resp  output  N_PORTS  per-master HREADYOUT.
src_hresp  output  N_PORTS  per-master HRESP.
src_haddr  input  N_PORTS*W_ADDR  per-master address.
src_hwrite  input  N_PORTS  per-master write flag.
src_htrans  input  N_PORTS*2  per-master transfer type.
src_hsize  input  N_PORTS*3  per-master transfer size.
src_hburst  input  N_PORTS*3  per-master burst type.
src_hprot  input  N_PORTS*4  per-master protection bits.
src_hmastlock  input  N_PORTS  per-master lock request.
src_hwdata  input  N_PORTS*W_DATA  per-master write data.
src_hrdata  output  N_PORTS*W_DATA  read data, broadcast to all masters.
dst_hready  output  1  driven equal to dst_hready_resp.
dst_hready_resp  input  1  downstream HREADYOUT.
dst_hresp  input  1  downstream HRESP.
dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock  output  W_ADDR/1/2/3/3/4/1  muxed address-phase signals.
dst_hwdata  output  W_DATA  muxed write data.
dst_hrdata  input  W_DATA  downstream read data.

Behaviour:
- Live request of port i: src_htrans[i]!=IDLE and src_hready[i].
- Effective request: req[i] = buf_valid[i] | live request of port i.
- Source selection: if buf_valid[i], port i's effective address-phase signals come from its buffer; otherwise they come from its live inputs.
- Grant (combinational, grant_a, one-hot):
  - If the lock register is set, grant_a holds the locked port.
  - Otherwise grant_a is the lowest-index req.
  - If there are no requests, grant_a=0 and dst_htrans=IDLE.
- dst address-phase signals are the granted port's effective signals. With no grant: dst_htrans=IDLE and the other dst address signals are don't-care.
- Address-phase acceptance happens when dst_hready_resp=1.
- On acceptance:
  - grant_d <= grant_a.
  - buf_valid of the granted port clears.
  - lock <= granted port if its effective hmastlock=1, else lock clears.
- While dst_hready_resp=0: grant_a, the dst address signals, grant_d and lock are all held.
- Buffer capture: a port's buffer loads the full address phase (addr, write, trans, size, burst, prot, mastlock) when that port has a live request but is not accepted this cycle. This covers both losing arbitration and dst_hready_resp=0. It sets buf_valid. The buffer is never overwritten while valid.
- src_hready_resp[i] = grant_d[i] ? dst_hready_resp : !buf_valid[i].
  - A buffered master sees one continuous stall, then completion in its replayed data phase.
- src_hresp[i] = grant_d[i] & dst_hresp.
- Ungranted ports with no buffered request see hready_resp=1, hresp=0.
- dst_hwdata = src_hwdata of the port flagged in grant_d; 0 if none.
- src_hrdata is dst_hrdata broadcast to all masters.
- Two-cycle error response:
  - Both cycles are forwarded only to the port flagged in grant_d.
  - src_hready is low in the first error cycle, so no capture occurs and the master may switch htrans to IDLE.
  - A transfer already buffered is still replayed.
- Simultaneous events:
  - A port cannot hold a buffered and a live request at once, because its hready is low while buffered.
  - A buffered request outranks higher-index live requests only through fixed priority; there is no ageing.
- Reset (async):
  - buf_valid=0, grant_d=0, lock=0.
  - Outputs: dst_htrans=IDLE, src_hready_resp=all 1, src_hresp=0, dst_hwdata=0.
  - A reset mid-transfer drops buffered requests.
- Latency: zero added cycles for an uncontended master; each lost arbitration adds at least one stall cycle.

Test Plan:
1. Port1 alone issues NONSEQ read at 0x2000_0010, slave returns 0xDEADBEEF with no wait → dst_htrans=NONSEQ in the same cycle; src_hrdata=0xDEADBEEF and src_hready_resp[1]=1 in the next cycle.
2. Ports 0 and 1 issue NONSEQ in the same cycle (0x100 write 0x11, 0x200 write 0x22) → port0 is passed first and port1 is buffered with src_hready_resp[1]=0. The 0x200 address appears on dst one cycle later. dst_hwdata=0x22 in port1's data phase; src_hready_resp[1] returns to 1 only then.
3. dst_hready_resp held 0 for 3 cycles while port1 presents an address → port1 is buffered. dst signals stay stable, then the 0x200 transfer issues after the stall with no loss.
4. Port1 asserts hmastlock on two back-to-back transfers while port0 requests → port0 is held off until port1's unlocked transfer has been accepted, then port0 is granted.
5. Slave gives a two-cycle ERROR to port0 → src_hresp[0]=1 with hready_resp 0 then 1. Port1 sees hresp=0 throughout.
6. Assert rst_n low while port1 is buffered → buf_valid clears, dst_htrans=IDLE, all src_hready_resp=1.

Source files
------------

// File: rtl/ahbl_arbiter_if.sv
// AHB-lite bus bundle for the N:1 arbiter: per-master upstream signals (flattened
// vectors, port i in slice i) plus the single downstream master port.
interface ahbl_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
);
  logic [N_PORTS-1:0]        src_hready;
  logic [N_PORTS-1:0]        src_hready_resp;
  logic [N_PORTS-1:0]        src_hresp;
  logic [N_PORTS*W_ADDR-1:0] src_haddr;
  logic [N_PORTS-1:0]        src_hwrite;
  logic [N_PORTS*2-1:0]      src_htrans;
  logic [N_PORTS*3-1:0]      src_hsize;
  logic [N_PORTS*3-1:0]      src_hburst;
  logic [N_PORTS*4-1:0]      src_hprot;
  logic [N_PORTS-1:0]        src_hmastlock;
  logic [N_PORTS*W_DATA-1:0] src_hwdata;
  logic [N_PORTS*W_DATA-1:0] src_hrdata;

  logic              dst_hready;
  logic              dst_hready_resp;
  logic              dst_hresp;
  logic [W_ADDR-1:0] dst_haddr;
  logic              dst_hwrite;
  logic [1:0]        dst_htrans;
  logic [2:0]        dst_hsize;
  logic [2:0]        dst_hburst;
  logic [3:0]        dst_hprot;
  logic              dst_hmastlock;
  logic [W_DATA-1:0] dst_hwdata;
  logic [W_DATA-1:0] dst_hrdata;

  // slave: the arbiter itself (slave to the upstream masters, master downstream)
  modport slave (
    input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
           src_hprot, src_hmastlock, src_hwdata,
           dst_hready_resp, dst_hresp, dst_hrdata,
    output src_hready_resp, src_hresp, src_hrdata,
           dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
           dst_hprot, dst_hmastlock, dst_hwdata
  );

  // master: the environment (upstream masters plus the downstream slave)
  modport master (
    output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
           src_hprot, src_hmastlock, src_hwdata,
           dst_hready_resp, dst_hresp, dst_hrdata,
    input  src_hready_resp, src_hresp, src_hrdata,
           dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
           dst_hprot, dst_hmastlock, dst_hwdata
  );
endinterface

// File: rtl/ahbl_arbiter.sv
// Fixed-priority N:1 AHB-lite arbiter; losing masters get their address phase
// buffered and are stalled until the replayed transfer completes.
module ahbl_arbiter #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input logic          clk,
  input logic          rst_n,
  ahbl_arbiter_if.slave bus
);
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef struct packed {
    logic [W_ADDR-1:0] addr;
    logic              write;
    logic [1:0]        trans;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
  } aphase_t;

  aphase_t live_ap [N_PORTS];
  aphase_t eff_ap  [N_PORTS];
  aphase_t buf_q   [N_PORTS];
  aphase_t dst_ap;

  logic [N_PORTS-1:0] live_req, req, capture, eff_lock;
  logic [N_PORTS-1:0] buf_valid_q, buf_valid_d;
  logic [N_PORTS-1:0] grant_a, prio;
  logic [N_PORTS-1:0] grant_d_q, grant_d_d;
  logic [N_PORTS-1:0] lock_q, lock_d;
  logic [N_PORTS-1:0] hold_q, hold_d;
  logic [W_DATA-1:0]  hwdata_mux;
  logic               accept;

  assign accept = bus.dst_hready_resp;

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign live_ap[gi] = '{
        addr:  bus.src_haddr[gi*W_ADDR +: W_ADDR],
        write: bus.src_hwrite[gi],
        trans: bus.src_htrans[gi*2 +: 2],
        size:  bus.src_hsize[gi*3 +: 3],
        burst: bus.src_hburst[gi*3 +: 3],
        prot:  bus.src_hprot[gi*4 +: 4],
        lock:  bus.src_hmastlock[gi]
      };

      assign live_req[gi] = (live_ap[gi].trans != HTRANS_IDLE) && bus.src_hready[gi];
      assign req[gi]      = buf_valid_q[gi] | live_req[gi];
      assign eff_ap[gi]   = buf_valid_q[gi] ? buf_q[gi] : live_ap[gi];
      assign eff_lock[gi] = eff_ap[gi].lock;

      // Any live request that does not go out this cycle is parked, whether it
      // lost arbitration or the downstream slave is stalling.
      assign capture[gi] = live_req[gi] && !buf_valid_q[gi] && !(accept && grant_a[gi]);

      assign buf_valid_d[gi] = capture[gi] ? 1'b1 :
                               (accept && grant_a[gi]) ? 1'b0 : buf_valid_q[gi];

      always_ff @(posedge clk) begin
        if (capture[gi]) begin
          buf_q[gi] <= live_ap[gi];
        end
      end

      assign bus.src_hready_resp[gi] = grant_d_q[gi] ? accept : !buf_valid_q[gi];
      assign bus.src_hresp[gi]       = grant_d_q[gi] & bus.dst_hresp;
      assign bus.src_hrdata[gi*W_DATA +: W_DATA] = bus.dst_hrdata;
    end
  endgenerate

  always_comb begin
    prio = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        prio    = '0;
        prio[i] = 1'b1;
      end
    end
  end

  // A grant issued during a wait state stays put until the slave is ready.
  always_comb begin
    grant_a = prio;
    if (|hold_q) begin
      grant_a = hold_q;
    end else if (|lock_q) begin
      grant_a = lock_q;
    end
  end

  always_comb begin
    dst_ap = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_a[i]) begin
        dst_ap = eff_ap[i];
      end
    end
  end

  always_comb begin
    hwdata_mux = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_d_q[i]) begin
        hwdata_mux = bus.src_hwdata[i*W_DATA +: W_DATA];
      end
    end
  end

  always_comb begin
    grant_d_d = grant_d_q;
    lock_d    = lock_q;
    hold_d    = '0;
    if (accept) begin
      grant_d_d = grant_a;
      lock_d    = (|(grant_a & eff_lock)) ? grant_a : '0;
    end else begin
      hold_d = grant_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= '0;
      grant_d_q   <= '0;
      lock_q      <= '0;
      hold_q      <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      grant_d_q   <= grant_d_d;
      lock_q      <= lock_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.dst_hready    = bus.dst_hready_resp;
  assign bus.dst_haddr     = dst_ap.addr;
  assign bus.dst_hwrite    = dst_ap.write;
  assign bus.dst_htrans    = dst_ap.trans;
  assign bus.dst_hsize     = dst_ap.size;
  assign bus.dst_hburst    = dst_ap.burst;
  assign bus.dst_hprot     = dst_ap.prot;
  assign bus.dst_hmastlock = dst_ap.lock;
  assign bus.dst_hwdata    = hwdata_mux;
endmodule
